// File: rtl/sram_like_mem_slave.sv
// Responder end of the sram-like req/addr_ok/data_ok interface.
// Requests are queued in acceptance order. Each one answers exactly LATENCY
// edges after it was accepted. Writes reach the word memory only when they
// retire, so an in-order read that follows a pending write sees the new data.
module sram_like_mem_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  input  logic        addr_stall
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = 4;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] LAT_AGE   = AGE_W'(LATENCY);

  // Word memory; intentionally never reset so contents survive resetn.
  logic [31:0] mem [2**ADDR_WIDTH];

  logic [DEPTH-1:0]      q_valid;
  logic [DEPTH-1:0]      q_wr;
  logic [ADDR_WIDTH-1:0] q_idx   [DEPTH];
  logic [3:0]            q_mask  [DEPTH];
  logic [31:0]           q_wdata [DEPTH];
  logic [AGE_W-1:0]      q_age   [DEPTH];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  push;
  logic                  pop;
  logic [3:0]            req_mask;
  logic [ADDR_WIDTH-1:0] req_idx;

  // Byte address bits above the word index simply alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^data_addr[31:ADDR_WIDTH+2];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // No bypass: a slot freed by this cycle's retire is only visible next cycle.
  assign data_addr_ok = ~addr_stall & (count < DEPTH_CNT);
  assign push         = data_req & data_addr_ok;
  assign data_data_ok = q_valid[head] & (q_age[head] == LAT_AGE);
  assign pop          = data_data_ok;
  assign req_idx      = data_addr[ADDR_WIDTH+1:2];

  // Byte-lane mask of the incoming request, frozen into the queue on accept.
  always_comb begin
    req_mask = 4'b1111;
    case (data_size)
      2'd0:    req_mask = 4'b0001 << data_addr[1:0];
      2'd1:    req_mask = data_addr[1] ? 4'b1100 : 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  // Read data is driven only during a read response; zero otherwise.
  always_comb begin
    data_rdata = '0;
    if (data_data_ok && !q_wr[head]) begin
      data_rdata = mem[q_idx[head]];
    end
  end

  // Request queue: ageing, push at the tail, pop of the responding head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      q_wr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_idx[i]   <= '0;
        q_mask[i]  <= '0;
        q_wdata[i] <= '0;
        q_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && (q_age[i] != LAT_AGE)) begin
          q_age[i] <= q_age[i] + 1'b1;
        end
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= ptr_next(head);
      end
      // The tail slot is always free when push is possible, so it never
      // collides with the ageing loop or with the head being popped.
      if (push) begin
        q_valid[tail] <= 1'b1;
        q_wr[tail]    <= data_wr;
        q_idx[tail]   <= req_idx;
        q_mask[tail]  <= req_mask;
        q_wdata[tail] <= data_wdata;
        q_age[tail]   <= '0;
        tail          <= ptr_next(tail);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A write commits its masked bytes on the edge that ends its response cycle.
  always_ff @(posedge clk) begin
    if (pop && q_wr[head]) begin
      for (int b = 0; b < 4; b++) begin
        if (q_mask[head][b]) begin
          mem[q_idx[head]][8*b +: 8] <= q_wdata[head][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: two instances (LATENCY 2 and 6, DEPTH 4)
// share one master; sel picks which one receives requests. A transaction-level
// model predicts every cycle's addr_ok/data_ok/rdata from accept times and an
// in-order word memory.
module tb_sram_like_mem_slave;

  localparam int DEPTH_V = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall = 1'b0;
  logic        sel = 1'b0;

  logic        req_a, req_b;
  logic [31:0] rdata_a, rdata_b, rdata;
  logic        addr_ok_a, addr_ok_b, addr_ok;
  logic        data_ok_a, data_ok_b, data_ok;

  assign req_a   = req & ~sel;
  assign req_b   = req & sel;
  assign rdata   = sel ? rdata_b : rdata_a;
  assign addr_ok = sel ? addr_ok_b : addr_ok_a;
  assign data_ok = sel ? data_ok_b : data_ok_a;

  sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(2), .DEPTH(DEPTH_V)) dut_a (
    .clk(clk), .resetn(resetn), .data_req(req_a), .data_wr(wr), .data_size(size),
    .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata_a),
    .data_addr_ok(addr_ok_a), .data_data_ok(data_ok_a), .addr_stall(stall));

  sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(6), .DEPTH(DEPTH_V)) dut_b (
    .clk(clk), .resetn(resetn), .data_req(req_b), .data_wr(wr), .data_size(size),
    .data_addr(addr), .data_wdata(wdata), .data_rdata(rdata_b),
    .data_addr_ok(addr_ok_b), .data_data_ok(data_ok_b), .addr_stall(stall));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { int due; logic wr; logic [31:0] rdata; } exp_t;

  req_t        pend[$];
  exp_t        mq[$];
  logic [31:0] mmem [int];
  int          acc_edges[$];
  int          rsp_cycles[$];
  logic [31:0] rsp_data[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          last_acc;
  bit          rand_stall = 1'b0;

  function automatic int lat();
    return sel ? 6 : 2;
  endfunction

  function automatic int mkey(input logic [31:0] a);
    return (sel ? 65536 : 0) + int'(a[13:2]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int k = mkey(a);
    return mmem.exists(k) ? mmem[k] : 32'h0;
  endfunction

  function automatic void model_write(input req_t r);
    logic [31:0] w;
    logic [3:0]  m;
    int k = mkey(r.addr);
    w = mmem.exists(k) ? mmem[k] : 32'h0;
    case (r.size)
      2'd0:    m = 4'b0001 << r.addr[1:0];
      2'd1:    m = r.addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
    mmem[k] = w;
  endfunction

  function automatic void clear_logs();
    acc_edges.delete();
    rsp_cycles.delete();
    rsp_data.delete();
  endfunction

  // One clock cycle: compare outputs mid-cycle against the model, note an accept.
  task automatic tick();
    logic        exp_ok, exp_aok;
    logic [31:0] exp_rd;
    exp_t        e;
    req_t        r;
    @(negedge clk);
    while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
    exp_ok  = (mq.size() > 0) && (mq[0].due == cyc);
    exp_rd  = exp_ok ? mq[0].rdata : 32'h0;
    exp_aok = !stall && (mq.size() < DEPTH_V);
    n_vec++;
    if (data_ok !== exp_ok) begin
      n_err++;
      $display("FAIL data_ok cyc=%0d sel=%0d got=%b exp=%b", cyc, sel, data_ok, exp_ok);
    end
    n_vec++;
    if (rdata !== exp_rd) begin
      n_err++;
      $display("FAIL rdata cyc=%0d sel=%0d got=%h exp=%h", cyc, sel, rdata, exp_rd);
    end
    n_vec++;
    if (addr_ok !== exp_aok) begin
      n_err++;
      $display("FAIL addr_ok cyc=%0d sel=%0d got=%b exp=%b", cyc, sel, addr_ok, exp_aok);
    end
    if (data_ok === 1'b1) begin
      rsp_cycles.push_back(cyc);
      rsp_data.push_back(rdata);
    end
    last_acc = req && exp_aok;
    if (last_acc) begin
      r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata;
      e.due   = cyc + 1 + lat();
      e.wr    = wr;
      e.rdata = wr ? 32'h0 : model_read(addr);
      if (wr) model_write(r);
      mq.push_back(e);
      acc_edges.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle();
    if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    if (pend.size() > 0) begin
      req = 1'b1; wr = pend[0].wr; size = pend[0].size;
      addr = pend[0].addr; wdata = pend[0].wdata;
    end else begin
      req = 1'b0; wr = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
      addr = $urandom; wdata = $urandom;
    end
    tick();
    if (last_acc) void'(pend.pop_front());
    req = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((pend.size() > 0 || mq.size() > 0) && n < bound) begin
      drive_cycle();
      n++;
    end
    n_vec++;
    if (pend.size() != 0 || mq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending=%0d outstanding=%0d after %0d cycles", pend.size(), mq.size(), n);
      pend.delete();
      mq.delete();
    end
  endtask

  function automatic void push_req(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.wr = w; r.size = s; r.addr = a; r.wdata = d;
    pend.push_back(r);
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL reset_addr_ok got=%b exp=1", addr_ok); end
    n_vec++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL reset_data_ok got=%b exp=0", data_ok); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    // Two reads get accepted, then reset lands before either can answer.
    sel = 1'b0;
    push_req(1'b0, 2'd2, 32'h0000_0040, 32'h0);
    push_req(1'b0, 2'd2, 32'h0000_0044, 32'h0);
    push_req(1'b0, 2'd2, 32'h0000_0048, 32'h0);
    drive_cycle();
    drive_cycle();
    #3;
    resetn = 1'b0;
    req = 1'b0;
    pend.delete();
    mq.delete();
    #1;
    n_vec++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL midrun_reset_addr_ok got=%b exp=1", addr_ok); end
    n_vec++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL midrun_reset_data_ok got=%b exp=0", data_ok); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL midrun_reset_rdata got=%h exp=0", rdata); end
    @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    repeat (8) drive_cycle();
    n_vec++;
    if (rsp_cycles.size() != 0) begin
      n_err++;
      $display("FAIL stale_response got=%0d responses exp=0", rsp_cycles.size());
    end
  endtask

  task automatic test_word_rw();
    sel = 1'b0;
    clear_logs();
    push_req(1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF);
    drain(50);
    n_vec++;
    if (acc_edges.size() != 1 || rsp_cycles.size() != 1 || rsp_cycles[0] - acc_edges[0] != 2) begin
      n_err++;
      $display("FAIL write_latency got acc=%0d rsp=%0d exp one response 2 edges after accept", acc_edges.size(), rsp_cycles.size());
    end
    clear_logs();
    push_req(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    drain(50);
    n_vec++;
    if (rsp_data.size() != 1 || rsp_data[0] !== 32'hDEAD_BEEF || rsp_cycles[0] - acc_edges[0] != 2) begin
      n_err++;
      $display("FAIL read_word got n=%0d data=%h exp=deadbeef at latency 2", rsp_data.size(), rsp_data.size() > 0 ? rsp_data[0] : 32'h0);
    end
  endtask

  task automatic test_byte_half();
    sel = 1'b0;
    clear_logs();
    push_req(1'b1, 2'd0, 32'h0000_0101, 32'h0000_AA00);
    push_req(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    push_req(1'b1, 2'd1, 32'h0000_0102, 32'h1234_0000);
    push_req(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    drain(50);
    n_vec++;
    if (rsp_data.size() != 4 || rsp_data[1] !== 32'hDEAD_AAEF) begin
      n_err++;
      $display("FAIL store_byte got=%h exp=deadaaef", rsp_data.size() > 1 ? rsp_data[1] : 32'h0);
    end
    n_vec++;
    if (rsp_data.size() != 4 || rsp_data[3] !== 32'h1234_AAEF) begin
      n_err++;
      $display("FAIL store_half got=%h exp=1234aaef", rsp_data.size() > 3 ? rsp_data[3] : 32'h0);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [8];
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      push_req(1'b1, 2'd2, 32'h0000_0200 + 32'(i * 4), vals[i]);
    end
    drain(100);
    clear_logs();
    for (int i = 0; i < 8; i++) push_req(1'b0, 2'd2, 32'h0000_0200 + 32'(i * 4), 32'h0);
    drain(100);
    n_vec++;
    if (acc_edges.size() != 8 || rsp_cycles.size() != 8) begin
      n_err++;
      $display("FAIL stream_count got acc=%0d rsp=%0d exp 8/8", acc_edges.size(), rsp_cycles.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (acc_edges[i] != acc_edges[0] + i || rsp_cycles[i] != acc_edges[0] + 2 + i || rsp_data[i] !== vals[i]) begin
          n_err++;
          $display("FAIL stream_%0d got acc=%0d rsp=%0d data=%h exp acc=%0d rsp=%0d data=%h", i,
                   acc_edges[i], rsp_cycles[i], rsp_data[i], acc_edges[0] + i, acc_edges[0] + 2 + i, vals[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] w;
    sel = 1'b1;
    for (int i = 0; i < 5; i++) push_req(1'b1, 2'd2, 32'h0000_0400 + 32'(i * 4), $urandom);
    drain(200);
    clear_logs();
    for (int i = 0; i < 5; i++) push_req(1'b0, 2'd2, 32'h0000_0400 + 32'(i * 4), 32'h0);
    drain(200);
    n_vec++;
    if (acc_edges.size() != 5 || rsp_cycles.size() != 5) begin
      n_err++;
      $display("FAIL full_count got acc=%0d rsp=%0d exp 5/5", acc_edges.size(), rsp_cycles.size());
    end else begin
      n_vec++;
      if (acc_edges[3] != acc_edges[0] + 3 || acc_edges[4] != rsp_cycles[0] + 2) begin
        n_err++;
        $display("FAIL full_fifth_accept got edge=%0d exp=%0d", acc_edges[4], rsp_cycles[0] + 2);
      end
    end
    clear_logs();
    w = $urandom;
    push_req(1'b1, 2'd2, 32'h0000_0410, w);
    push_req(1'b0, 2'd2, 32'h0000_0410, 32'h0);
    drain(200);
    n_vec++;
    if (rsp_data.size() != 2 || rsp_data[1] !== w) begin
      n_err++;
      $display("FAIL write_then_read got=%h exp=%h", rsp_data.size() > 1 ? rsp_data[1] : 32'h0, w);
    end
  endtask

  task automatic test_stall();
    int rel;
    sel = 1'b0;
    clear_logs();
    push_req(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    stall = 1'b1;
    repeat (3) drive_cycle();
    n_vec++;
    if (acc_edges.size() != 0) begin
      n_err++;
      $display("FAIL stall_accept got=%0d accepts exp=0", acc_edges.size());
    end
    stall = 1'b0;
    rel = cyc + 1;
    drain(50);
    n_vec++;
    if (acc_edges.size() != 1 || acc_edges[0] != rel || rsp_cycles.size() != 1 || rsp_cycles[0] != rel + 2) begin
      n_err++;
      $display("FAIL stall_release got acc=%0d rsp=%0d exp acc=%0d rsp=%0d",
               acc_edges.size() > 0 ? acc_edges[0] : -1, rsp_cycles.size() > 0 ? rsp_cycles[0] : -1, rel, rel + 2);
    end
    n_vec++;
    if (rsp_data.size() != 1 || rsp_data[0] !== 32'h1234_AAEF) begin
      n_err++;
      $display("FAIL stall_data got=%h exp=1234aaef", rsp_data.size() > 0 ? rsp_data[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    req_t r;
    int   nops;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 16; i++) push_req(1'b1, 2'd2, 32'h0000_0C00 + 32'(i * 4), $urandom);
      drain(300);
    end
    rand_stall = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      sel = 1'($urandom_range(0, 1));
      clear_logs();
      nops = $urandom_range(20, 40);
      for (int k = 0; k < nops; k++) begin
        r.wr = 1'($urandom_range(0, 1));
        r.size = 2'($urandom_range(0, 3));
        r.addr = $urandom;
        r.addr[13:2] = 12'h300 + 12'($urandom_range(0, 15));
        r.wdata = $urandom;
        pend.push_back(r);
      end
      drain(2000);
      n_vec++;
      if (acc_edges.size() != nops || rsp_cycles.size() != nops) begin
        n_err++;
        $display("FAIL rand_count seg=%0d got acc=%0d rsp=%0d exp=%0d", seg, acc_edges.size(), rsp_cycles.size(), nops);
      end
      for (int i = 0; i < acc_edges.size() && i < rsp_cycles.size(); i++) begin
        n_vec++;
        if (rsp_cycles[i] - acc_edges[i] != lat()) begin
          n_err++;
          $display("FAIL rand_latency seg=%0d idx=%0d got=%0d exp=%0d", seg, i, rsp_cycles[i] - acc_edges[i], lat());
        end
      end
    end
    rand_stall = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_streaming();
    test_full();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
